spmv_mem_req_sched: RTL and testbench

- Shares the single DCP memory request/response port among NUM_REQ SpMV fetch clients: matrix-stream fetcher, dense-x gather and output writeback-read.
- Arbitrates requests round-robin and allocates 6-bit transids from a free pool capped at MAX_OUT outstanding.
- Records the owner and local tag of each transid, then routes each response back to its owner.
- Sits between the SpMV fetch/gather units and the DCP NoC memory interface.

---
 rtl/spmv_mem_req_sched_if.sv | 37 +++
 rtl/spmv_mem_req_sched.sv | 149 ++++++++++++++
 tb/tb_spmv_mem_req_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_mem_req_sched_if.sv
// Bus bundle between the SpMV fetch clients, the request scheduler and the DCP memory port.
// The master modport is the scheduler's view; slave is the view of the clients plus memory.
interface spmv_mem_req_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int ADDR_W  = 40,
  parameter int RESP_W  = 512
);
  logic [NUM_REQ-1:0]        cl_req_val;
  logic [NUM_REQ-1:0]        cl_req_rdy;
  logic [NUM_REQ*ADDR_W-1:0] cl_req_addr;
  logic [NUM_REQ*TAG_W-1:0]  cl_req_tag;
  logic                      mem_req_val;
  logic                      mem_req_rdy;
  logic [5:0]                mem_req_transid;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic                      mem_resp_val;
  logic [5:0]                mem_resp_transid;
  logic [RESP_W-1:0]         mem_resp_data;
  logic [NUM_REQ-1:0]        cl_resp_val;
  logic [TAG_W-1:0]          cl_resp_tag;
  logic [RESP_W-1:0]         cl_resp_data;

  modport master (
    input  cl_req_val, cl_req_addr, cl_req_tag, mem_req_rdy,
           mem_resp_val, mem_resp_transid, mem_resp_data,
    output cl_req_rdy, mem_req_val, mem_req_transid, mem_req_addr,
           cl_resp_val, cl_resp_tag, cl_resp_data
  );

  modport slave (
    output cl_req_val, cl_req_addr, cl_req_tag, mem_req_rdy,
           mem_resp_val, mem_resp_transid, mem_resp_data,
    input  cl_req_rdy, mem_req_val, mem_req_transid, mem_req_addr,
           cl_resp_val, cl_resp_tag, cl_resp_data
  );
endinterface

// File: rtl/spmv_mem_req_sched.sv
// Round-robin scheduler sharing one DCP memory port among SpMV fetch clients:
// allocates transids from a free pool, remembers owner/tag per transid and routes responses back.
module spmv_mem_req_sched #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 16,
  parameter int TAG_W   = 4,
  parameter int ADDR_W  = 40,
  parameter int RESP_W  = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spmv_mem_req_sched_if.master bus,
  output logic [6:0]           outstanding,
  output logic                 idle,
  output logic                 err_bad_transid
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [0:0] {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;
  state_t state_r, state_next_s;

  logic [MAX_OUT-1:0] busy_r, busy_next_s;
  logic [GW-1:0]      owner_r [MAX_OUT];
  logic [TAG_W-1:0]   tag_r   [MAX_OUT];
  logic [GW-1:0]      rr_ptr_r, lock_gnt_r, rr_gnt_s, gnt_s, cand_s;
  logic [SW-1:0]      lock_slot_r, free_slot_s, slot_s, resp_slot_s;
  logic               rr_found_s, take_s, free_exists_s, req_val_s, hs_s, resp_ok_s;
  logic [NUM_REQ-1:0] cl_req_rdy_s;
  logic [ADDR_W-1:0]  req_addr_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic [6:0]         outstanding_r;
  logic               err_r;
  logic [NUM_REQ-1:0] resp_val_r;
  logic [TAG_W-1:0]   resp_tag_r;
  logic [RESP_W-1:0]  resp_data_r;

  // Lowest free slot and round-robin candidate search.
  always_comb begin
    free_slot_s   = '0;
    free_exists_s = 1'b0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      free_exists_s = free_exists_s | ~busy_r[i];
      free_slot_s   = busy_r[i] ? free_slot_s : SW'(i);
    end
    rr_gnt_s   = rr_ptr_r;
    rr_found_s = 1'b0;
    cand_s     = '0;
    take_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s     = GW'((int'(rr_ptr_r) + k) % NUM_REQ);
      take_s     = ~rr_found_s & bus.cl_req_val[cand_s];
      rr_gnt_s   = take_s ? cand_s : rr_gnt_s;
      rr_found_s = rr_found_s | take_s;
    end
  end

  // Request path: a locked grant holds client, transid and address until accepted.
  always_comb begin
    gnt_s        = (state_r == ST_LOCKED) ? lock_gnt_r : rr_gnt_s;
    slot_s       = (state_r == ST_LOCKED) ? lock_slot_r : free_slot_s;
    req_val_s    = (state_r == ST_LOCKED) | ((|bus.cl_req_val) & free_exists_s);
    hs_s         = req_val_s & bus.mem_req_rdy;
    req_addr_s   = '0;
    req_tag_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_s = (gnt_s == GW'(i)) ? bus.cl_req_addr[i*ADDR_W +: ADDR_W] : req_addr_s;
      req_tag_s  = (gnt_s == GW'(i)) ? bus.cl_req_tag[i*TAG_W +: TAG_W] : req_tag_s;
    end
    cl_req_rdy_s        = '0;
    cl_req_rdy_s[gnt_s] = hs_s;
  end

  // Lock FSM next state: stalled requests may not be retracted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_OPEN:   state_next_s = (req_val_s & ~bus.mem_req_rdy) ? ST_LOCKED : ST_OPEN;
      ST_LOCKED: state_next_s = bus.mem_req_rdy ? ST_OPEN : ST_LOCKED;
      default:   state_next_s = ST_OPEN;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_OPEN;
    else        state_r <= state_next_s;
  end

  // Capture the stalled grant when the lock is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_gnt_r  <= '0;
      lock_slot_r <= '0;
    end else if ((state_r == ST_OPEN) && (state_next_s == ST_LOCKED)) begin
      lock_gnt_r  <= rr_gnt_s;
      lock_slot_r <= free_slot_s;
    end
  end

  // Slot bookkeeping: an allocation and a free never target the same slot.
  always_comb begin
    resp_slot_s = bus.mem_resp_transid[SW-1:0];
    resp_ok_s   = bus.mem_resp_val && (int'(bus.mem_resp_transid) < MAX_OUT) && busy_r[resp_slot_s];
    busy_next_s = (busy_r | (MAX_OUT'(hs_s) << slot_s)) & ~(MAX_OUT'(resp_ok_s) << resp_slot_s);
  end

  // Slot table, RR pointer, counters and registered response path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r        <= '0;
      rr_ptr_r      <= '0;
      outstanding_r <= 7'd0;
      err_r         <= 1'b0;
      resp_val_r    <= '0;
      resp_tag_r    <= '0;
      resp_data_r   <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        owner_r[i] <= '0;
        tag_r[i]   <= '0;
      end
    end else begin
      busy_r        <= busy_next_s;
      outstanding_r <= outstanding_r + 7'(hs_s) - 7'(resp_ok_s);
      if (hs_s) begin
        owner_r[slot_s] <= gnt_s;
        tag_r[slot_s]   <= req_tag_s;
        rr_ptr_r        <= (gnt_s == GW'(NUM_REQ - 1)) ? '0 : gnt_s + GW'(1);
      end
      resp_val_r <= resp_ok_s ? (NUM_REQ'(1'b1) << owner_r[resp_slot_s]) : '0;
      if (resp_ok_s) begin
        resp_tag_r  <= tag_r[resp_slot_s];
        resp_data_r <= bus.mem_resp_data;
      end
      if (bus.mem_resp_val && !resp_ok_s) err_r <= 1'b1;
    end
  end

  assign bus.cl_req_rdy      = cl_req_rdy_s;
  assign bus.mem_req_val     = req_val_s;
  assign bus.mem_req_transid = 6'(slot_s);
  assign bus.mem_req_addr    = req_addr_s;
  assign bus.cl_resp_val     = resp_val_r;
  assign bus.cl_resp_tag     = resp_tag_r;
  assign bus.cl_resp_data    = resp_data_r;
  assign outstanding         = outstanding_r;
  assign idle                = (outstanding_r == 7'd0) && (state_r == ST_OPEN);
  assign err_bad_transid     = err_r;
endmodule

// File: tb/tb_spmv_mem_req_sched.sv
// Bench for spmv_mem_req_sched: vector table for arbitration/lock behaviour, hand sequences
// for full pool, bad transids and reset, with a response scoreboard checked every cycle.
module tb_spmv_mem_req_sched;
  localparam int NR = 4;
  localparam int MO = 16;
  localparam int TW = 4;
  localparam int AW = 40;
  localparam int RW = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] outstanding;
  logic       idle;
  logic       err_bad_transid;

  always #5 clk = ~clk;

  spmv_mem_req_sched_if #(.NUM_REQ(NR), .TAG_W(TW), .ADDR_W(AW), .RESP_W(RW)) bus ();

  spmv_mem_req_sched #(.NUM_REQ(NR), .MAX_OUT(MO), .TAG_W(TW), .ADDR_W(AW), .RESP_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .outstanding(outstanding), .idle(idle), .err_bad_transid(err_bad_transid)
  );

  typedef struct {
    logic [NR-1:0] cl_val;
    logic          rdy;
    logic          rv;
    logic [5:0]    rt;
    logic          exp_mval;
    logic [NR-1:0] exp_crdy;
    logic [5:0]    exp_tid;
    int            exp_g;
  } vec_t;

  typedef struct {
    logic [NR-1:0] val;
    logic [TW-1:0] tag;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  vec_t          tbl[12];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          m_busy[64];
  int            m_owner[64];
  logic [TW-1:0] m_tag[64];
  logic [AW-1:0] c_addr[NR];
  logic [TW-1:0] c_tag[NR];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_clients(input logic [NR-1:0] v);
    bus.cl_req_val = v;
    for (int i = 0; i < NR; i++) begin
      bus.cl_req_addr[i*AW +: AW] = c_addr[i];
      bus.cl_req_tag[i*TW +: TW]  = c_tag[i];
    end
  endtask

  // One clock; afterwards compare the registered response outputs against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("resp_val", bus.cl_resp_val, e.val);
      chk("resp_tag", bus.cl_resp_tag, e.tag);
      chk("resp_data", bus.cl_resp_data, e.data);
    end else begin
      chk("no_resp", bus.cl_resp_val, 4'b0000);
    end
  endtask

  task automatic note_alloc(input int tid, input int g);
    m_busy[tid]  = 1'b1;
    m_owner[tid] = g;
    m_tag[tid]   = c_tag[g];
  endtask

  task automatic send_resp(input logic [5:0] t, input logic [RW-1:0] d);
    exp_t e;
    bus.mem_resp_val     = 1'b1;
    bus.mem_resp_transid = t;
    bus.mem_resp_data    = d;
    if (t < 6'd16 && m_busy[t]) begin
      e.val  = NR'(1) << m_owner[t];
      e.tag  = m_tag[t];
      e.data = d;
      e.cyc  = cyc + 1;
      sbq.push_back(e);
      m_busy[t] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_clients(4'b0000);
    bus.mem_req_rdy  = 1'b0;
    bus.mem_resp_val = 1'b0;
    sbq.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cl_req_val       = 4'b0000;
    bus.cl_req_addr      = '0;
    bus.cl_req_tag       = '0;
    bus.mem_req_rdy      = 1'b0;
    bus.mem_resp_val     = 1'b0;
    bus.mem_resp_transid = 6'd0;
    bus.mem_resp_data    = '0;
    for (int i = 0; i < NR; i++) begin
      c_addr[i] = 40'hA0_0000_0000 + 40'(i * 64);
      c_tag[i]  = 4'(i + 4);
    end

    // Reset state.
    do_reset();
    #1;
    chk("rst_outstanding", outstanding, 7'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err_bad_transid, 1'b0);
    chk("rst_resp_tag", bus.cl_resp_tag, 4'd0);
    chk("rst_mem_req_val", bus.mem_req_val, 1'b0);

    // Single request from client 1 and its response.
    c_addr[1] = 40'h1000;
    c_tag[1]  = 4'd3;
    bus.mem_req_rdy = 1'b1;
    drive_clients(4'b0010);
    #1;
    chk("t1_mval", bus.mem_req_val, 1'b1);
    chk("t1_tid", bus.mem_req_transid, 6'd0);
    chk("t1_addr", bus.mem_req_addr, 40'h1000);
    chk("t1_crdy", bus.cl_req_rdy, 4'b0010);
    note_alloc(0, 1);
    step();
    drive_clients(4'b0000);
    chk("t1_out1", outstanding, 7'd1);
    chk("t1_busy", idle, 1'b0);
    send_resp(6'd0, {16{32'hC0DE_0001}});
    step();
    bus.mem_resp_val = 1'b0;
    chk("t1_out0", outstanding, 7'd0);
    chk("t1_idle", idle, 1'b1);

    // Round-robin wrap, then lock hold while client 0 competes with the stalled client 2.
    do_reset();
    c_tag[1] = 4'd5;
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0001, 6'd0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0010, 6'd1, 1};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0100, 6'd2, 2};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 6'd0, 1'b1, 4'b1000, 6'd3, 3};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0001, 6'd4, 0};
    tbl[5]  = '{4'b1000, 1'b1, 1'b0, 6'd0, 1'b1, 4'b1000, 6'd5, 3};
    tbl[6]  = '{4'b0100, 1'b0, 1'b0, 6'd0, 1'b1, 4'b0000, 6'd6, 2};
    tbl[7]  = '{4'b0101, 1'b0, 1'b1, 6'd0, 1'b1, 4'b0000, 6'd6, 2};
    tbl[8]  = '{4'b0101, 1'b0, 1'b0, 6'd0, 1'b1, 4'b0000, 6'd6, 2};
    tbl[9]  = '{4'b0101, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0100, 6'd6, 2};
    tbl[10] = '{4'b0001, 1'b1, 1'b0, 6'd0, 1'b1, 4'b0001, 6'd0, 0};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 6'd0, 1'b0, 4'b0000, 6'd0, 0};
    for (int r = 0; r < 12; r++) begin
      drive_clients(tbl[r].cl_val);
      bus.mem_req_rdy = tbl[r].rdy;
      if (tbl[r].rv) send_resp(tbl[r].rt, {16{32'(r)}});
      else bus.mem_resp_val = 1'b0;
      #1;
      chk($sformatf("v%0d_mval", r), bus.mem_req_val, tbl[r].exp_mval);
      chk($sformatf("v%0d_crdy", r), bus.cl_req_rdy, tbl[r].exp_crdy);
      if (tbl[r].exp_mval) begin
        chk($sformatf("v%0d_tid", r), bus.mem_req_transid, tbl[r].exp_tid);
        chk($sformatf("v%0d_addr", r), bus.mem_req_addr, c_addr[tbl[r].exp_g]);
      end
      if (tbl[r].exp_crdy != 4'b0000) note_alloc(int'(tbl[r].exp_tid), tbl[r].exp_g);
      step();
    end
    bus.mem_resp_val = 1'b0;
    drive_clients(4'b0000);
    chk("tbl_outstanding", outstanding, 7'd7);
    chk("tbl_err", err_bad_transid, 1'b0);

    // Fill the pool: slots 0..6 busy, client 1 takes 7..15, then the port closes.
    bus.mem_req_rdy = 1'b1;
    drive_clients(4'b0010);
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("fill%0d_tid", k), bus.mem_req_transid, 6'(7 + k));
      chk($sformatf("fill%0d_crdy", k), bus.cl_req_rdy, 4'b0010);
      note_alloc(7 + k, 1);
      step();
    end
    chk("full_outstanding", outstanding, 7'd16);
    chk("full_mval", bus.mem_req_val, 1'b0);
    chk("full_crdy", bus.cl_req_rdy, 4'b0000);
    chk("full_idle", idle, 1'b0);
    send_resp(6'd5, {16{32'hFEED_0005}});
    #1;
    chk("full_mval_resp_cycle", bus.mem_req_val, 1'b0);
    step();
    bus.mem_resp_val = 1'b0;
    #1;
    chk("refill_mval", bus.mem_req_val, 1'b1);
    chk("refill_tid", bus.mem_req_transid, 6'd5);
    note_alloc(5, 1);
    step();
    drive_clients(4'b0000);
    chk("refill_outstanding", outstanding, 7'd16);

    // Out-of-range transid.
    do_reset();
    send_resp(6'd20, {16{32'hBAD0_0020}});
    step();
    bus.mem_resp_val = 1'b0;
    chk("oor_err", err_bad_transid, 1'b1);
    step();
    step();
    chk("oor_err_sticky", err_bad_transid, 1'b1);

    // Response to a free slot.
    do_reset();
    chk("free_err_cleared", err_bad_transid, 1'b0);
    send_resp(6'd7, {16{32'hBAD0_0007}});
    step();
    bus.mem_resp_val = 1'b0;
    chk("free_err", err_bad_transid, 1'b1);
    chk("free_outstanding", outstanding, 7'd0);

    // Reset with three in flight abandons them.
    do_reset();
    bus.mem_req_rdy = 1'b1;
    drive_clients(4'b0100);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mid%0d_tid", k), bus.mem_req_transid, 6'(k));
      note_alloc(k, 2);
      step();
    end
    drive_clients(4'b0000);
    chk("mid_outstanding3", outstanding, 7'd3);
    do_reset();
    chk("mid_outstanding0", outstanding, 7'd0);
    chk("mid_idle", idle, 1'b1);
    send_resp(6'd1, {16{32'h0DD0_0001}});
    step();
    bus.mem_resp_val = 1'b0;
    chk("mid_err", err_bad_transid, 1'b1);
    chk("mid_outstanding_after", outstanding, 7'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
